// File: rtl/ct_spsram_4096x84_acc_ctrl.sv
// Access sequencer for the 4096x84 single-port SRAM: valid/ready requests in, CEN/GWEN/WEN out, one-entry read buffer.
// Define CT_SPSRAM_ACC_INIT_EN to sweep INIT_VAL through the whole array after reset before accepting traffic.
module ct_spsram_4096x84_acc_ctrl #(
  parameter int unsigned           ADDR_WIDTH = 12,
  parameter int unsigned           DATA_WIDTH = 84,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  logic                  run;
  logic                  init_wr;
  logic [ADDR_WIDTH-1:0] init_addr;

`ifdef CT_SPSRAM_ACC_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
      if (init_cnt_q == '1) state_d = ST_RUN;
    end
  end

  // State already reads INIT during reset; the sweep write itself must stay off until cpurst drops.
  always_comb begin
    run       = (state_q == ST_RUN);
    init_wr   = (state_q == ST_INIT) && !cpurst;
    init_addr = init_cnt_q;
    init_done = run;
  end
`else
  always_comb begin
    run       = !cpurst;
    init_wr   = 1'b0;
    init_addr = '0;
    init_done = !cpurst;
  end
`endif

  logic                  rd_inflight_q, rd_inflight_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rd_ok;
  logic                  acc_wr;
  logic                  acc_rd;

  // A read may enter only if its data will have a free buffer slot when it returns.
  always_comb begin
    rd_ok   = !rd_inflight_q && (!rsp_vld_q || rsp_rdy);
    req_rdy = run && (req_wr || rd_ok);
    acc_wr  = req_vld && req_rdy && req_wr;
    acc_rd  = req_vld && req_rdy && !req_wr;
  end

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (init_wr) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_addr;
      sram_d    = INIT_VAL;
    end else if (acc_wr) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = ~req_wmask;
      sram_a    = req_addr;
      sram_d    = req_wdata;
    end else if (acc_rd) begin
      sram_cen  = 1'b0;
      sram_a    = req_addr;
    end
  end

  always_comb begin
    rd_inflight_d = acc_rd;
    rsp_vld_d     = rsp_vld_q;
    rsp_rdata_d   = rsp_rdata_q;
    if (rd_inflight_q) begin
      rsp_vld_d   = 1'b1;
      rsp_rdata_d = sram_q;
    end else if (rsp_vld_q && rsp_rdy) begin
      rsp_vld_d   = 1'b0;
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      rd_inflight_q <= 1'b0;
      rsp_vld_q     <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      rd_inflight_q <= rd_inflight_d;
      rsp_vld_q     <= rsp_vld_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  always_comb begin
    rsp_vld   = rsp_vld_q;
    rsp_rdata = rsp_rdata_q;
  end

endmodule
